// File: rtl/act_skew_feeder_if.sv
// Activation input stream bundle for act_skew_feeder.
// master drives in_valid/in_data/in_last; slave returns in_ready.
interface act_skew_feeder_if #(
  parameter int N      = 14,
  parameter int DATA_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [N*DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Triangular-skew activation feeder for an NxN systolic array.
// Ports: clk, rst_n, start, wgt_busy, s (input stream), a_out,
// en_out, clr_out, busy, done; perf_beats/perf_bubbles when
// ACT_SKEW_PERF_EN is defined.
module act_skew_feeder #(
  parameter int N      = 14,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                wgt_busy,
  act_skew_feeder_if.slave    s,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N-1:0]        en_out,
  output logic [N-1:0]        clr_out,
  output logic                busy,
  output logic                done
`ifdef ACT_SKEW_PERF_EN
  ,
  output logic [31:0]         perf_beats,
  output logic [31:0]         perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH
  } state_t;

  localparam int CW = $clog2(N + 1);
  // N=1 has no skew: one flush cycle still needed.
  localparam logic [CW-1:0] CNT_INIT =
    CW'((N > 1) ? (N - 1) : 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [N-1:0]  r_en;
  logic [N-1:0]  r_clr;

  logic w_rdy;
  logic w_hs;
  logic w_clr_h;

  assign w_rdy      = (r_state == S_STREAM) && !wgt_busy;
  assign s.in_ready = w_rdy;
  assign w_hs       = s.in_valid && w_rdy;
  assign w_clr_h    = (r_state == S_CLEAR);

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign en_out  = r_en;
  assign clr_out = r_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_hs && s.in_last) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_INIT;
          end
        end
        S_FLUSH: begin
          // done lands one cycle later, with the
          // last beat on lane N-1.
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // en/clr are shared by all lanes: stage r feeds row r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= '0;
      r_clr <= '0;
    end else begin
      r_en[0]  <= w_hs;
      r_clr[0] <= w_clr_h;
      for (int i = 1; i < N; i++) begin
        r_en[i]  <= r_en[i-1];
        r_clr[i] <= r_clr[i-1];
      end
    end
  end

  // Lane r: head plus r delay stages of its own data.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [DATA_W-1:0] r_sh [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) r_sh[i] <= '0;
      end else begin
        r_sh[0] <= w_hs ?
          s.in_data[r*DATA_W +: DATA_W] : '0;
        for (int i = 1; i <= r; i++)
          r_sh[i] <= r_sh[i-1];
      end
    end

    assign a_out[r*DATA_W +: DATA_W] = r_sh[r];
  end

`ifdef ACT_SKEW_PERF_EN
  logic w_bub;
  assign w_bub = (r_state == S_STREAM) && !w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats   <= '0;
      perf_bubbles <= '0;
    end else if (r_state == S_IDLE && start) begin
      perf_beats   <= '0;
      perf_bubbles <= '0;
    end else begin
      if (w_hs && perf_beats != '1)
        perf_beats <= perf_beats + 32'd1;
      if (w_bub && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (N=14, INT8).
// Records per-cycle outputs, checks against hand timing.
module tb_act_skew_feeder;
  localparam int N  = 14;
  localparam int DW = 8;
  localparam int HL = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic wgt_busy = 1'b0;
  logic [N*DW-1:0] a_out;
  logic [N-1:0] en_out;
  logic [N-1:0] clr_out;
  logic busy;
  logic done;
`ifdef ACT_SKEW_PERF_EN
  logic [31:0] perf_beats;
  logic [31:0] perf_bubbles;
`endif

  act_skew_feeder_if #(.N(N), .DATA_W(DW)) bus ();

  act_skew_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .wgt_busy(wgt_busy),
    .s(bus.slave),
    .a_out(a_out),
    .en_out(en_out),
    .clr_out(clr_out),
    .busy(busy),
    .done(done)
`ifdef ACT_SKEW_PERF_EN
    ,
    .perf_beats(perf_beats),
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N*DW-1:0] h_a   [HL];
  logic [N-1:0]    h_en  [HL];
  logic [N-1:0]    h_clr [HL];
  logic            h_done[HL];
  logic            h_rdy [HL];
  logic            h_busy[HL];

  always @(negedge clk) begin
    if (cyc < HL) begin
      h_a[cyc]    <= a_out;
      h_en[cyc]   <= en_out;
      h_clr[cyc]  <= clr_out;
      h_done[cyc] <= done;
      h_rdy[cyc]  <= bus.in_ready;
      h_busy[cyc] <= busy;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [N*DW-1:0] mk(input int base);
    logic [N*DW-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'(base + r);
    return v;
  endfunction

  function automatic logic [DW-1:0] lane(input int c,
                                         input int r);
    logic [N*DW-1:0] v;
    v = h_a[c];
    return v[r*DW +: DW];
  endfunction

  task automatic beat(input logic v,
                      input logic [N*DW-1:0] d,
                      input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic do_start(output int s);
    step();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int s;
  int nd;

  initial begin
    beat(1'b0, '0, 1'b0);
    // reset and idle
    idle(2);
    rst_n = 1'b1;
    idle(5);
    chk("rst_a", a_out, 0);
    chk("rst_en", en_out, 0);
    chk("rst_clr", clr_out, 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // three back-to-back beats, stray start in FLUSH
    do_start(s);
    step();
    beat(1'b1, mk(0), 1'b0);
    step();
    beat(1'b1, mk(10), 1'b0);
    step();
    beat(1'b1, mk(20), 1'b1);
    step();
    beat(1'b0, '0, 1'b0);
    idle(5);
    start = 1'b1;
    step();
    start = 1'b0;
    idle(12);
    for (int r = 0; r < N; r += 6) begin
      chk($sformatf("t2_clr_r%0d", r), h_clr[s+2+r][r], 1);
      chk($sformatf("t2_clrpre_r%0d", r), h_clr[s+1+r][r], 0);
      chk($sformatf("t2_clren_r%0d", r), h_en[s+2+r][r], 0);
    end
    chk("t2_clr_r13", h_clr[s+15][13], 1);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < N; r++) begin
        chk($sformatf("t2_a_k%0d_r%0d", k, r),
            lane(s+3+k+r, r), 10*k + r);
        chk($sformatf("t2_en_k%0d_r%0d", k, r),
            h_en[s+3+k+r][r], 1);
      end
    chk("t2_l13_33", lane(s+18, 13), 33);
    chk("t2_done", h_done[s+18], 1);
    chk("t2_done_pre", h_done[s+17], 0);
    chk("t2_busy_pre", h_busy[s+17], 1);
    chk("t2_busy_end", h_busy[s+18], 0);
    chk("t2_busy_ign", h_busy[s+20], 0);
    nd = 0;
    for (int c = s; c < s+22; c++) nd += int'(h_done[c]);
    chk("t2_ndone", nd, 1);

    // two-cycle gap between beats
    do_start(s);
    step();
    beat(1'b1, mk(8'h40), 1'b0);
    step();
    beat(1'b0, '0, 1'b0);
    idle(2);
    beat(1'b1, mk(8'h50), 1'b1);
    step();
    beat(1'b0, '0, 1'b0);
    idle(20);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("t3_b0_r%0d", r), lane(s+3+r, r), 8'h40 + r);
      chk($sformatf("t3_gap_a_r%0d", r),
          {lane(s+4+r, r), lane(s+5+r, r)}, 0);
      chk($sformatf("t3_gap_en_r%0d", r),
          {h_en[s+4+r][r], h_en[s+5+r][r]}, 0);
      chk($sformatf("t3_b1_r%0d", r), lane(s+6+r, r), 8'h50 + r);
      chk($sformatf("t3_b1en_r%0d", r), h_en[s+6+r][r], 1);
    end
    chk("t3_done", h_done[s+19], 1);
`ifdef ACT_SKEW_PERF_EN
    chk("t3_bubbles", perf_bubbles, 2);
    chk("t3_beats", perf_beats, 2);
`endif

    // weight load stalls the stream for 4 cycles
    do_start(s);
    step();
    beat(1'b1, mk(8'h60), 1'b0);
    step();
    beat(1'b1, mk(8'h70), 1'b0);
    wgt_busy = 1'b1;
    repeat (4) step();
    wgt_busy = 1'b0;
    step();
    beat(1'b1, mk(8'h80), 1'b1);
    step();
    beat(1'b0, '0, 1'b0);
    idle(20);
    chk("t4_rdy", {h_rdy[s+2], h_rdy[s+3], h_rdy[s+4],
        h_rdy[s+5], h_rdy[s+6], h_rdy[s+7], h_rdy[s+8]},
        7'b1000011);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("t4_b0_r%0d", r), lane(s+3+r, r), 8'h60 + r);
      chk($sformatf("t4_gap_r%0d", r),
          {h_en[s+4+r][r], h_en[s+5+r][r],
           h_en[s+6+r][r], h_en[s+7+r][r]}, 0);
      chk($sformatf("t4_b1_r%0d", r), lane(s+8+r, r), 8'h70 + r);
      chk($sformatf("t4_b2_r%0d", r), lane(s+9+r, r), 8'h80 + r);
      chk($sformatf("t4_b2en_r%0d", r), h_en[s+9+r][r], 1);
      chk($sformatf("t4_post_r%0d", r), h_en[s+10+r][r], 0);
    end
    chk("t4_done", h_done[s+22], 1);

    // single-beat tile, valid already up with start
    step();
    s = cyc;
    start = 1'b1;
    beat(1'b1, {N{8'h7F}}, 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    beat(1'b0, '0, 1'b0);
    idle(20);
    chk("t5_rdy", {h_rdy[s], h_rdy[s+1], h_rdy[s+2]}, 3'b001);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("t5_a_r%0d", r), lane(s+3+r, r), 8'h7F);
      chk($sformatf("t5_en_r%0d", r), h_en[s+3+r][r], 1);
      chk($sformatf("t5_enpre_r%0d", r), h_en[s+2+r][r], 0);
    end
    chk("t5_done", h_done[s+16], 1);
    chk("t5_done_pre", h_done[s+15], 0);

    // reset during FLUSH, then a clean tile
    step();
    s = cyc;
    start = 1'b1;
    beat(1'b1, mk(1), 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    beat(1'b0, '0, 1'b0);
    idle(3);
    chk("t6_inflush", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_a", a_out, 0);
    chk("t6_rst_en", en_out, 0);
    chk("t6_rst_clr", clr_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_rdy", bus.in_ready, 0);
    idle(2);
    rst_n = 1'b1;
    idle(18);
    nd = 0;
    for (int c = s+3; c < s+24; c++) nd += int'(h_done[c]);
    chk("t6_nodone", nd, 0);
    step();
    s = cyc;
    start = 1'b1;
    beat(1'b1, mk(8'h20), 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    beat(1'b0, '0, 1'b0);
    idle(20);
    chk("t6_l0", lane(s+3, 0), 8'h20);
    chk("t6_l13", lane(s+16, 13), 8'h2D);
    chk("t6_done", h_done[s+16], 1);
    chk("t6_idle", h_busy[s+17], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // en and clr never coincide on any row
  always @(negedge clk) begin
    if (rst_n && (en_out & clr_out) != '0)
      chk("en_clr_excl", en_out & clr_out, 0);
  end

endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Upstream activation feeder for the N×N weight-stationary systolic array.
- Accepts one N-lane INT8 activation vector per beat over valid/ready.
- Delays lane r by r cycles (triangular skew) and drives each row's west-edge a_in, plus skewed per-row en and clr.
- Sequences one tile: clear, stream, flush. Blocks input while a weight load is in progress, because en and load_weight are mutually exclusive.

Parameters:
- N, 14, array rows and activation lanes.
- DATA_W, 8, activation width (signed).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begin a tile (honoured only in IDLE)
- wgt_busy  input  1  weight load in progress; suppresses input acceptance
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  N*DATA_W  lane r at bits [r*DATA_W +: DATA_W]
- in_last  input  1  final beat of the tile, qualified by handshake
- a_out  output  N*DATA_W  skewed activations; lane r drives row r a_in
- en_out  output  N  skewed MAC enable per row
- clr_out  output  N  skewed accumulator clear per row
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the flush completes

Behaviour:
- Reset: state IDLE; all skew registers zero. a_out=0, en_out=0, clr_out=0, in_ready=0, busy=0, done=0.
- Lane 0 head register loads every cycle with (data, en, clr) chosen by state. Lane r output is the head value delayed r further cycles through a shift chain of depth r. Chains shift every cycle; there is no back-pressure from the array.
- Latency: a beat accepted at cycle t appears on a_out lane r at cycle t+1+r, with en_out[r]=1.
- States and transitions:
  - IDLE: in_ready=0. Head loads (0, en=0, clr=0). start -> CLEAR.
  - CLEAR: exactly one cycle. Head loads (0, en=0, clr=1). in_ready=0. -> STREAM.
  - STREAM: in_ready = !wgt_busy.
    - Handshake: head loads (in_data lane 0, en=1, clr=0).
    - No handshake (bubble): head loads (0, en=0, clr=0).
    - Handshake with in_last -> FLUSH, with flush counter = N-1.
  - FLUSH: in_ready=0. Head loads zeros with en=0. Counter decrements each cycle. At counter==1, done pulses in the cycle the last skewed beat is on lane N-1; next state IDLE.
- Lanes 1..N-1 pick up their own in_data lanes at the handshake. Each lane's chain entry carries that lane's value, and en/clr shift in lockstep with data.
- Boundaries:
  - start outside IDLE is ignored.
  - start and in_valid in the same cycle in IDLE: no beat is accepted.
  - wgt_busy rising mid-STREAM: in_ready drops that same cycle (combinational) and bubbles are inserted. Beats already in the chains drain unaffected.
  - in_last on the first beat is legal: 1-beat tile.
  - N=1: FLUSH lasts 1 cycle, no skew stages.
- Reset mid-operation: all state and chains are cleared asynchronously. No done is emitted for the aborted tile.
- Invariant: en_out[r] and clr_out[r] are never both 1.

Optional Feature:
- Macro ACT_SKEW_PERF_EN.
- Defined: adds outputs perf_beats[31:0] and perf_bubbles[31:0].
  - perf_beats counts accepted beats.
  - perf_bubbles counts STREAM cycles without a handshake.
  - Both counters clear on start in IDLE, saturate at all-ones, and reset to 0.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, in_ready=0, busy=0.
- N=14, start, then 3 back-to-back beats with lane r = 10*k+r for beat k=0,1,2; in_last on k=2 -> clr_out[r]=1 at cycle T_clr+1+r; a_out lane 13 = 13, 23, 33 on consecutive cycles with en_out[13]=1; done pulses the same cycle 33 appears on lane 13; then IDLE.
- in_valid dropped for 2 cycles between beats 0 and 1 -> each lane shows a 2-cycle gap with en_out=0 and a_out=0; perf_bubbles=2 when ACT_SKEW_PERF_EN is defined.
- wgt_busy held high 4 cycles in STREAM with in_valid=1 -> in_ready=0 for exactly those cycles, no beat lost or duplicated, en_out all 0 for the corresponding skewed windows.
- Single-beat tile (in_last on the first beat, data 0x7F on all lanes) -> lane r shows 0x7F at t+1+r; done pulses at t+14 (N=14).
- rst_n asserted mid-FLUSH -> outputs 0 immediately, no done pulse; subsequent start runs a clean tile.
